srt4_control_unit: RTL and testbench

SRT4_CONTROL_UNIT -- requirements
Module: srt4_control_unit

---
 rtl/srt4_pkg.sv | 73 +++++++
 rtl/srt4_digit_sel.sv | 31 +++
 rtl/srt4_control_unit.sv | 161 ++++++++++++++++
 tb/tb_srt4_control_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/srt4_pkg.sv
// Shared types and constants for the radix-4 SRT divider control unit.
// Holds the FSM state encoding, the quotient-digit encoding and the digit-selection thresholds.
package srt4_pkg;

    localparam int ITER_DEFAULT = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_NORM,
        S_DIGIT,
        S_SHIFT,
        S_ADD,
        S_CORR,
        S_FINAL,
        S_DENORM,
        S_DONE
    } state_e;

    // Signed quotient digit, two's complement in three bits.
    typedef enum logic [2:0] {
        DIG_Z  = 3'b000,
        DIG_P1 = 3'b001,
        DIG_P2 = 3'b010,
        DIG_N2 = 3'b110,
        DIG_N1 = 3'b111
    } digit_e;

    // Lower bound of each digit's p_top interval; anything below N1 selects -2.
    localparam logic signed [3:0] P_TOP_P2_MIN = 4'sd3;
    localparam logic signed [3:0] P_TOP_P1_MIN = 4'sd1;
    localparam logic signed [3:0] P_TOP_Z_MIN  = -4'sd1;
    localparam logic signed [3:0] P_TOP_N1_MIN = -4'sd3;

    // p2 -> c7, p1 -> c4, m1 -> c5, m2 -> c6
    typedef struct packed {
        logic p2;
        logic p1;
        logic m1;
        logic m2;
    } digit_flags_t;

    typedef struct packed {
        logic         c0;
        logic         c1;
        logic         c2;
        logic         c3;
        digit_flags_t dig;
        logic         c8;
        logic         c9;
        logic         c10;
        logic         c11;
        logic         c12;
        logic         c13;
        logic         c14;
        logic         busy;
        logic         done;
    } ctrl_t;

    function automatic digit_flags_t digit_to_flags(input digit_e d);
        digit_flags_t f;
        f = '0;
        case (d)
            DIG_P2:  f.p2 = 1'b1;
            DIG_P1:  f.p1 = 1'b1;
            DIG_N1:  f.m1 = 1'b1;
            DIG_N2:  f.m2 = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/srt4_digit_sel.sv
// Radix-4 quotient digit selection from the signed partial-remainder estimate.
// Purely combinational; the control unit registers its result only when entering DIGIT.
module srt4_digit_sel
    import srt4_pkg::*;
(
    input  logic [3:0]   p_top,
    output digit_flags_t flags
);

    logic signed [3:0] v;
    digit_e            digit;

    assign v = signed'(p_top);

    always_comb begin
        if (v >= P_TOP_P2_MIN) begin
            digit = DIG_P2;
        end else if (v >= P_TOP_P1_MIN) begin
            digit = DIG_P1;
        end else if (v >= P_TOP_Z_MIN) begin
            digit = DIG_Z;
        end else if (v >= P_TOP_N1_MIN) begin
            digit = DIG_N1;
        end else begin
            digit = DIG_N2;
        end
    end

    assign flags = digit_to_flags(digit);

endmodule

// File: rtl/srt4_control_unit.sv
// Control sequencer for an 8-bit radix-4 SRT divider.
// Every strobe is the registered image of the state being entered, so outputs come straight from flops.
module srt4_control_unit
    import srt4_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic       b_msb,
    input  logic [3:0] p_top,
    input  logic       p_sign,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       c8,
    output logic       c9,
    output logic       c10,
    output logic       c11,
    output logic       c12,
    output logic       c13,
    output logic       c14,
    output logic       busy,
    output logic       done,
    output logic       div0
);

    localparam int IW = $clog2(ITER + 1);

    state_e          state_q, state_n;
    ctrl_t           ctrl_q, ctrl_n;
    logic [2:0]      norm_cnt_q, norm_cnt_n;
    logic [IW-1:0]   iter_cnt_q, iter_cnt_n;
    logic            div0_q, div0_n;
    digit_flags_t    sel_flags;

    srt4_digit_sel u_digit_sel (
        .p_top (p_top),
        .flags (sel_flags)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n    = state_q;
        ctrl_n     = '0;
        norm_cnt_n = norm_cnt_q;
        iter_cnt_n = iter_cnt_q;
        div0_n     = div0_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_INIT;
                    ctrl_n.c0  = 1'b1;
                    ctrl_n.c1  = 1'b1;
                    norm_cnt_n = '0;
                    iter_cnt_n = '0;
                    div0_n     = 1'b0;
                end
            end
            S_INIT: state_n = S_NORM;
            S_NORM: begin
                if (b_msb) begin
                    state_n    = S_DIGIT;
                    ctrl_n.dig = sel_flags;
                end else if (norm_cnt_q == 3'd7) begin
                    // Seven shifts without a leading one: the divisor is zero.
                    state_n = S_DONE;
                    div0_n  = 1'b1;
                end else begin
                    ctrl_n.c2  = 1'b1;
                    norm_cnt_n = norm_cnt_q + 3'd1;
                end
            end
            S_DIGIT: begin
                state_n    = S_SHIFT;
                ctrl_n.c3  = 1'b1;
                ctrl_n.dig = ctrl_q.dig;
            end
            S_SHIFT: begin
                state_n    = S_ADD;
                ctrl_n.c8  = |ctrl_q.dig;
                ctrl_n.c9  = ctrl_q.dig.p2 | ctrl_q.dig.p1;
                ctrl_n.c10 = ctrl_q.dig.p2 | ctrl_q.dig.m2;
                iter_cnt_n = iter_cnt_q + IW'(1);
            end
            S_ADD: begin
                if (iter_cnt_q < IW'(ITER)) begin
                    state_n    = S_DIGIT;
                    ctrl_n.dig = sel_flags;
                end else begin
                    state_n    = S_CORR;
                    ctrl_n.c8  = p_sign;
                    ctrl_n.c11 = p_sign;
                    ctrl_n.c12 = p_sign;
                end
            end
            S_CORR: begin
                state_n    = S_FINAL;
                ctrl_n.c13 = 1'b1;
            end
            S_FINAL, S_DENORM: begin
                if (norm_cnt_q != 3'd0) begin
                    state_n    = S_DENORM;
                    ctrl_n.c14 = 1'b1;
                    norm_cnt_n = norm_cnt_q - 3'd1;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        ctrl_n.busy = (state_n != S_IDLE);
        ctrl_n.done = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            norm_cnt_q <= '0;
            iter_cnt_q <= '0;
            div0_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state and strobe flops update together from pre-edge values.
            state_q    <= state_n;
            ctrl_q     <= ctrl_n;
            norm_cnt_q <= norm_cnt_n;
            iter_cnt_q <= iter_cnt_n;
            div0_q     <= div0_n;
        end
    end

    assign c0   = ctrl_q.c0;
    assign c1   = ctrl_q.c1;
    assign c2   = ctrl_q.c2;
    assign c3   = ctrl_q.c3;
    assign c4   = ctrl_q.dig.p1;
    assign c5   = ctrl_q.dig.m1;
    assign c6   = ctrl_q.dig.m2;
    assign c7   = ctrl_q.dig.p2;
    assign c8   = ctrl_q.c8;
    assign c9   = ctrl_q.c9;
    assign c10  = ctrl_q.c10;
    assign c11  = ctrl_q.c11;
    assign c12  = ctrl_q.c12;
    assign c13  = ctrl_q.c13;
    assign c14  = ctrl_q.c14;
    assign busy = ctrl_q.busy;
    assign done = ctrl_q.done;
    assign div0 = div0_q;

endmodule

// File: tb/tb_srt4_control_unit.sv
// Scoreboard bench for srt4_control_unit: a small datapath stand-in drives b_msb/p_top,
// each division's expected strobe profile is queued at issue and compared when done pulses.
module tb_srt4_control_unit;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start;
    logic       b_msb;
    logic [3:0] p_top;
    logic       p_sign;
    logic c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14;
    logic busy, done, div0;

    srt4_control_unit #(.ITER(4)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .b_msb(b_msb), .p_top(p_top), .p_sign(p_sign),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .c8(c8), .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14),
        .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, busy, done, div0};

    typedef struct {
        int          lat;
        int          n_c2;
        int          n_c3;
        int          n_c13;
        int          n_c14;
        int          n_c11;
        bit          div0;
        logic [15:0] dig;
        logic [11:0] add;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic exp_t mk_exp(int lat, int n2, int n3, int n13, int n14, int n11,
                                    bit dz, logic [15:0] dig, logic [11:0] add);
        exp_t e;
        e.lat = lat; e.n_c2 = n2; e.n_c3 = n3; e.n_c13 = n13; e.n_c14 = n14;
        e.n_c11 = n11; e.div0 = dz; e.dig = dig; e.add = add;
        return e;
    endfunction

    // Datapath stand-in: b_msb rises after k_shifts normalize shifts; p_top steps per iteration.
    int          k_shifts = 0;
    int          shifts   = 0;
    logic [15:0] pseq     = '0;
    logic [15:0] pseq_sh  = '0;

    always @(negedge clk) begin
        if (c0) begin
            shifts  = 0;
            pseq_sh = pseq;
        end else if (c2) begin
            shifts++;
        end
        if (c3) pseq_sh = pseq_sh << 4;
        b_msb = (shifts >= k_shifts);
        p_top = pseq_sh[15:12];
    end

    // Monitor: accumulate one division's strobe profile, compare against the queue head at done.
    bit          active = 0;
    bit          after_c3 = 0;
    bit          prev_c11 = 0;
    bit          post_done = 0;
    int          lat, n2, n3, n13, n14, n11, hazards;
    logic [3:0]  prev_flags;
    logic [15:0] dig_seq;
    logic [11:0] add_seq;

    always @(negedge clk) begin
        if (!rst_b) begin
            active = 0;
            post_done = 0;
        end else begin
            if (post_done) begin
                check("idle_after_done", {30'd0, busy, done}, 32'd0);
                post_done = 0;
            end
            if (c0 && c1) begin
                active = 1; lat = 0; n2 = 0; n3 = 0; n13 = 0; n14 = 0; n11 = 0; hazards = 0;
                dig_seq = '0; add_seq = '0; after_c3 = 0; prev_c11 = 0; prev_flags = '0;
            end else if (active) begin
                lat++;
            end
            if (active) begin
                if (!busy) hazards++;
                if (c2) n2++;
                if (c3) begin
                    n3++;
                    dig_seq = {dig_seq[11:0], c7, c4, c5, c6};
                    if ({c7, c4, c5, c6} != prev_flags) hazards++;
                end
                if (after_c3) add_seq = {add_seq[8:0], c8, c9, c10};
                after_c3 = c3;
                if (c13) n13++;
                if (c14) n14++;
                if (c11) begin
                    n11++;
                    if (!(c8 && c12)) hazards++;
                end
                if (prev_c11 && !c13) hazards++;
                prev_c11 = c11;
                if ((c8 && c13) || (c2 && c3) || ($countones({c4, c5, c6, c7}) > 1)) hazards++;
                prev_flags = {c7, c4, c5, c6};
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("latency",   lat,            e.lat);
                        check("n_c2",      n2,             e.n_c2);
                        check("n_c3",      n3,             e.n_c3);
                        check("n_c13",     n13,            e.n_c13);
                        check("n_c14",     n14,            e.n_c14);
                        check("n_corr",    n11,            e.n_c11);
                        check("div0",      {31'd0, div0},  {31'd0, e.div0});
                        check("digit_seq", {16'd0, dig_seq}, {16'd0, e.dig});
                        check("add_seq",   {20'd0, add_seq}, {20'd0, e.add});
                        check("hazards",   hazards,        0);
                    end
                    active = 0;
                    post_done = 1;
                    done_count++;
                end
            end
        end
    end

    task automatic wait_done(input int prev);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_count > prev) break;
        end
        if (done_count <= prev) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [15:0] ps_seq, input logic ps,
                          input exp_t e, input bit extra_start);
        int prev;
        prev     = done_count;
        k_shifts = k;
        pseq     = ps_seq;
        p_sign   = ps;
        sb_q.push_back(e);
        pulse_start();
        if (extra_start) begin
            repeat (5) @(negedge clk);
            pulse_start();
        end
        wait_done(prev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst_b = 1'b0; start = 1'b0; p_sign = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {14'd0, outs}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // p_top=0 every digit, normalized divisor: four silent iterations, done 16 cycles after INIT.
        run_op(0, 16'h0000, 1'b0, mk_exp(16, 0, 4, 1, 0, 0, 0, 16'h0000, 12'h000), 0);
        // Three normalize shifts, sweep +2,+1,0,-2.
        run_op(3, 16'h72FC, 1'b0, mk_exp(22, 3, 4, 1, 3, 0, 0, 16'h8401, 12'hF85), 0);
        // Threshold edges 3,1,-1,-3 and a negative final remainder.
        run_op(0, 16'h31FD, 1'b1, mk_exp(16, 0, 4, 1, 0, 1, 0, 16'h8402, 12'hF84), 0);
        // Zero divisor: seven shifts then div0.
        run_op(8, 16'h0000, 1'b0, mk_exp(9, 7, 0, 0, 0, 0, 1, 16'h0000, 12'h000), 0);
        repeat (3) @(negedge clk);
        check("div0_held", {31'd0, div0}, 32'd1);
        // Maximum shift count, edges -2,-8,0,+1, plus a start pulse while busy.
        run_op(7, 16'hE801, 1'b1, mk_exp(30, 7, 4, 1, 7, 1, 0, 16'h2104, 12'h946), 1);

        // Abort during ADD.
        k_shifts = 0; pseq = 16'h7777; p_sign = 1'b0;
        pulse_start();
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c8) break;
        end
        check("abort_reached_add", {31'd0, c8}, 32'd1);
        rst_b = 1'b0;
        #1;
        check("abort_outputs_async", {14'd0, outs}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_outputs_held", {14'd0, outs}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        run_op(1, 16'h692B, 1'b0, mk_exp(18, 1, 4, 1, 1, 0, 0, 16'h8141, 12'hF75), 0);

        check("sb_drained", sb_q.size(), 32'd0);
        check("ops_completed", done_count, 32'd6);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
